// File: rtl/alu_result_wb_pkg.sv
// Shared types and constants for the ALU result write-back stage.
package alu_result_wb_pkg;

   localparam int WB_DW = 16;
   localparam int WB_AW = 3;

   localparam logic [WB_AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [WB_AW-1:0] dest;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ACTIVE,
      ST_FULL
   } drain_state_e;

endpackage

// File: rtl/alu_result_wb_if.sv
// ALU result stream: producer (master) pushes {dest, datain}, consumer (slave) returns in_ready.
interface alu_result_wb_if #(
   parameter int DW = 16,
   parameter int AW = 3
);

   logic [DW-1:0] datain;
   logic [AW-1:0] dest;
   logic          in_valid;
   logic          in_ready;

   modport master (output datain, output dest, output in_valid, input in_ready);
   modport slave  (input datain, input dest, input in_valid, output in_ready);

endinterface

// File: rtl/alu_result_wb_fifo.sv
// Result buffer: storage, head/tail pointers, occupancy and the derived drain state.
module wb_fifo
   import alu_result_wb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  wb_entry_t     wr_entry,
   output wb_entry_t     mem [DEPTH],
   output logic [PW-1:0] head,
   output logic [CW-1:0] count,
   output drain_state_e  state
);

   logic [PW-1:0] tail;
   logic          do_push;
   logic          do_pop;
   logic [CW-1:0] nxt_count;

   assign do_push = push && (state != ST_FULL);
   assign do_pop  = pop && (state != ST_EMPTY);

   always_comb begin
      nxt_count = count;
      if (do_push && !do_pop) begin
         nxt_count = count + CW'(1);
      end else if (do_pop && !do_push) begin
         nxt_count = count - CW'(1);
      end
   end

   // Flush shares the reset path so it wins over any push or pop in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= ST_EMPTY;
      end else begin
         if (do_push) begin
            mem[tail] <= wr_entry;
            tail      <= tail + PW'(1);
         end
         if (do_pop) begin
            head <= head + PW'(1);
         end
         count <= nxt_count;
         if (nxt_count == '0) begin
            state <= ST_EMPTY;
         end else if (nxt_count == CW'(DEPTH)) begin
            state <= ST_FULL;
         end else begin
            state <= ST_ACTIVE;
         end
      end
   end

endmodule

// File: rtl/alu_result_wb.sv
// Write-back stage: buffers ALU results, drains them through the shared register-file
// write port, and offers a bypass lookup over the still-pending results.
module alu_result_wb
   import alu_result_wb_pkg::*;
#(
   parameter  int DW    = WB_DW,
   parameter  int AW    = WB_AW,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   alu_result_wb_if.slave res,
   input  logic          flush,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   input  logic          rf_gnt,
   input  logic [AW-1:0] qry_addr,
   output logic          qry_hit,
   output logic [DW-1:0] qry_data,
   output logic [CW-1:0] count
);

   wb_entry_t     mem [DEPTH];
   wb_entry_t     wr_entry;
   logic [PW-1:0] head;
   drain_state_e  state;
   logic          push;

   // Writes to R0 are handshaken normally but never enter the buffer.
   assign res.in_ready = !rst && (state != ST_FULL);
   assign push         = res.in_valid && res.in_ready && (res.dest != REG_ZERO);
   assign wr_entry     = '{dest: res.dest, data: res.datain};

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (push),
      .pop      (rf_we && rf_gnt),
      .wr_entry (wr_entry),
      .mem      (mem),
      .head     (head),
      .count    (count),
      .state    (state)
   );

   // Head entry is masked while empty so stale storage never reaches the port.
   assign rf_we    = (state != ST_EMPTY);
   assign rf_waddr = rf_we ? mem[head].dest : '0;
   assign rf_wdata = rf_we ? mem[head].data : '0;

   // Walk from oldest to youngest so the last match found is the youngest.
   always_comb begin : bypass_search
      logic [PW-1:0] idx;
      idx      = head;
      qry_hit  = 1'b0;
      qry_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && (mem[idx].dest == qry_addr) && (qry_addr != REG_ZERO)) begin
            qry_hit  = 1'b1;
            qry_data = mem[idx].data;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_wb.sv
// Directed and reference-queue checks for the ALU result write-back stage.
module tb_alu_result_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        rf_gnt;
   logic [2:0]  qry_addr;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        qry_hit;
   logic [15:0] qry_data;
   logic [2:0]  count;

   int compared   = 0;
   int mismatched = 0;

   logic [18:0] refq[$];

   alu_result_wb_if #(.DW(16), .AW(3)) bus ();

   alu_result_wb #(
      .DW    (16),
      .AW    (3),
      .DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .res      (bus),
      .flush    (flush),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .rf_gnt   (rf_gnt),
      .qry_addr (qry_addr),
      .qry_hit  (qry_hit),
      .qry_data (qry_data),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] d, input logic [15:0] x,
                                input logic g, input logic f, input logic [2:0] q);
      bus.in_valid = v;
      bus.dest     = d;
      bus.datain   = x;
      rf_gnt       = g;
      flush        = f;
      qry_addr     = q;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        exp_hit;
      logic [15:0] exp_qd;
      logic        v, g, do_push;
      logic [2:0]  d, q;
      logic [15:0] x;

      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("reset in_ready", 32'(bus.in_ready), 0);
      checkOutput("reset count", 32'(count), 0);
      checkOutput("reset rf_we", 32'(rf_we), 0);
      checkOutput("reset rf_waddr", 32'(rf_waddr), 0);
      checkOutput("reset rf_wdata", 32'(rf_wdata), 0);
      checkOutput("reset qry_hit", 32'(qry_hit), 0);
      checkOutput("reset qry_data", 32'(qry_data), 0);
      rst = 1'b0;
      #1;
      checkOutput("post-reset in_ready", 32'(bus.in_ready), 1);

      $display("[TB] single push with grant");
      applyStimulus(1, 3, 16'h1234, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("t1 rf_we", 32'(rf_we), 1);
      checkOutput("t1 rf_waddr", 32'(rf_waddr), 3);
      checkOutput("t1 rf_wdata", 32'(rf_wdata), 32'h1234);
      checkOutput("t1 count", 32'(count), 1);
      tick();
      checkOutput("t1 count drained", 32'(count), 0);
      checkOutput("t1 rf_we drained", 32'(rf_we), 0);

      $display("[TB] fill to full without grant");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 3'(k + 1), 16'(16'h0100 + k), 0, 0, 0);
         checkOutput("t2 in_ready", 32'(bus.in_ready), (k < 4) ? 1 : 0);
         if (k < 4) tick();
      end
      checkOutput("t2 count full", 32'(count), 4);
      applyStimulus(1, 5, 16'h0104, 1, 0, 0);
      for (int j = 0; j < 5; j++) begin
         checkOutput("t2 drain rf_we", 32'(rf_we), 1);
         checkOutput("t2 drain rf_waddr", 32'(rf_waddr), 32'(j + 1));
         checkOutput("t2 drain rf_wdata", 32'(rf_wdata), 32'(16'h0100 + j));
         tick();
         if (j == 0) checkOutput("t2 in_ready after pop", 32'(bus.in_ready), 1);
         if (j == 1) applyStimulus(0, 0, 0, 1, 0, 0);
      end
      checkOutput("t2 count empty", 32'(count), 0);
      checkOutput("t2 rf_we empty", 32'(rf_we), 0);

      $display("[TB] same-dest bypass");
      applyStimulus(1, 2, 16'h0001, 0, 0, 2);
      tick();
      applyStimulus(1, 2, 16'h0002, 0, 0, 2);
      checkOutput("t3 bypass older only", 32'(qry_data), 32'h0001);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 2);
      checkOutput("t3 qry_hit", 32'(qry_hit), 1);
      checkOutput("t3 qry_data youngest", 32'(qry_data), 32'h0002);
      checkOutput("t3 count", 32'(count), 2);
      applyStimulus(0, 0, 0, 0, 0, 5);
      checkOutput("t3 qry miss hit", 32'(qry_hit), 0);
      checkOutput("t3 qry miss data", 32'(qry_data), 0);
      applyStimulus(0, 0, 0, 1, 0, 2);
      checkOutput("t3 first write", 32'(rf_wdata), 32'h0001);
      tick();
      checkOutput("t3 second write", 32'(rf_wdata), 32'h0002);
      checkOutput("t3 second waddr", 32'(rf_waddr), 2);
      tick();
      checkOutput("t3 count drained", 32'(count), 0);
      checkOutput("t3 qry_hit drained", 32'(qry_hit), 0);

      $display("[TB] push to R0");
      applyStimulus(1, 0, 16'hFFFF, 0, 0, 0);
      checkOutput("t4 in_ready", 32'(bus.in_ready), 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t4 count", 32'(count), 0);
      checkOutput("t4 rf_we", 32'(rf_we), 0);
      checkOutput("t4 qry_hit r0", 32'(qry_hit), 0);
      checkOutput("t4 qry_data r0", 32'(qry_data), 0);

      $display("[TB] flush with push and grant");
      applyStimulus(1, 1, 16'h0011, 0, 0, 0);
      tick();
      applyStimulus(1, 2, 16'h0022, 0, 0, 0);
      tick();
      applyStimulus(1, 3, 16'h0033, 0, 0, 0);
      tick();
      checkOutput("t5 count before flush", 32'(count), 3);
      applyStimulus(1, 4, 16'h0044, 1, 1, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 4);
      checkOutput("t5 count", 32'(count), 0);
      checkOutput("t5 rf_we", 32'(rf_we), 0);
      checkOutput("t5 lost input", 32'(qry_hit), 0);
      applyStimulus(1, 6, 16'h0066, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("t5 post-flush waddr", 32'(rf_waddr), 6);
      checkOutput("t5 post-flush wdata", 32'(rf_wdata), 32'h0066);
      tick();
      checkOutput("t5 post-flush drained", 32'(count), 0);

      $display("[TB] simultaneous push and pop");
      applyStimulus(1, 1, 16'h00A1, 0, 0, 0);
      tick();
      applyStimulus(1, 2, 16'h00A2, 0, 0, 0);
      tick();
      applyStimulus(1, 3, 16'h00A3, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("t6 count", 32'(count), 2);
      checkOutput("t6 head waddr", 32'(rf_waddr), 2);
      checkOutput("t6 head wdata", 32'(rf_wdata), 32'h00A2);
      tick();
      tick();
      checkOutput("t6 drained", 32'(count), 0);

      $display("[TB] random stream against reference queue");
      refq.delete();
      for (int c = 0; c < 100; c++) begin
         v = 1'($urandom_range(0, 1));
         d = 3'($urandom_range(0, 7));
         x = 16'($urandom_range(0, 65535));
         g = ($urandom_range(0, 2) == 0);
         q = 3'($urandom_range(0, 7));
         applyStimulus(v, d, x, g, 0, q);
         exp_hit = 1'b0;
         exp_qd  = '0;
         for (int i = refq.size() - 1; i >= 0; i--) begin
            if (!exp_hit && q != 0 && refq[i][18:16] == q) begin
               exp_hit = 1'b1;
               exp_qd  = refq[i][15:0];
            end
         end
         checkOutput("rnd in_ready", 32'(bus.in_ready), (refq.size() < 4) ? 1 : 0);
         checkOutput("rnd rf_we", 32'(rf_we), (refq.size() != 0) ? 1 : 0);
         if (refq.size() != 0) begin
            checkOutput("rnd rf_waddr", 32'(rf_waddr), 32'(refq[0][18:16]));
            checkOutput("rnd rf_wdata", 32'(rf_wdata), 32'(refq[0][15:0]));
         end
         checkOutput("rnd qry_hit", 32'(qry_hit), 32'(exp_hit));
         checkOutput("rnd qry_data", 32'(qry_data), 32'(exp_qd));
         do_push = v && (refq.size() < 4) && (d != 0);
         if (g && refq.size() != 0) void'(refq.pop_front());
         if (do_push) refq.push_back({d, x});
         tick();
         checkOutput("rnd count", 32'(count), 32'(refq.size()));
      end
      applyStimulus(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("rnd final drain", 32'(count), 0);

      $display("[TB] reset mid-operation");
      applyStimulus(1, 7, 16'h7777, 0, 0, 0);
      tick();
      applyStimulus(1, 6, 16'h6666, 0, 0, 0);
      tick();
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 7);
      checkOutput("rst mid in_ready", 32'(bus.in_ready), 0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("rst mid count", 32'(count), 0);
      checkOutput("rst mid rf_we", 32'(rf_we), 0);
      checkOutput("rst mid qry_hit", 32'(qry_hit), 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      tick();
      checkOutput("rst mid no write", 32'(rf_we), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_result_wb.md
# alu_result_wb

Write-back stage for the 16-bit RISC datapath. Consumes the registered ALU result stream with its destination register, buffers up to DEPTH results in a small FIFO, and drains them into the register-file write port. The write port is shared with the load path, so each write waits for a grant. Also provides a bypass lookup so decode can read a result that is still pending.

## Interface
- DW, 16: data width of ALU results and register-file data.
- AW, 3: register address width (8 architectural registers; R0 reads as zero).
- DEPTH, 4: result buffer entries; power of two, at least 2.

- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- datain  input  DW  ALU result.
- dest  input  AW  destination register of datain.
- in_valid  input  1  datain/dest valid this cycle.
- in_ready  output  1  buffer can accept; transfer when in_valid && in_ready.
- flush  input  1  discard all buffered results (pipeline squash).
- rf_we  output  1  write request to register file.
- rf_waddr  output  AW  write address (head entry dest).
- rf_wdata  output  DW  write data (head entry data).
- rf_gnt  input  1  write port granted; entry retires when rf_we && rf_gnt.
- qry_addr  input  AW  bypass lookup register.
- qry_hit  output  1  a pending entry targets qry_addr.
- qry_data  output  DW  data of the youngest matching pending entry; 0 when no hit.
- count  output  log2(DEPTH)+1  occupied entries.

## Operation
- Storage: DEPTH entries of {dest, data}, with head pointer, tail pointer, and count. Pointers wrap modulo DEPTH.
- Push: on in_valid && in_ready && !flush && dest != 0, write the entry at tail, then tail+1 and count+1.
- dest == 0: accepted (in_ready honoured) but dropped. No push, and count is unchanged.
- in_ready = !rst && (count < DEPTH). There is no same-cycle pass-through when full.
- Drain: rf_we = (count != 0). rf_waddr and rf_wdata come straight from the head entry.
- Pop: on rf_we && rf_gnt, head+1 and count−1.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any occupancy except full, where push is blocked.
- Ordering: results retire strictly in arrival order. Two entries with the same dest are both written, oldest first.
- flush: next cycle head = tail = 0 and count = 0. flush overrides push and pop in the same cycle, and rf_gnt in that cycle has no effect.
- Bypass: combinational search over occupied entries. Youngest match (closest to tail) wins. qry_addr == 0 gives qry_hit = 0 and qry_data = 0.
- Drain states are derived from count: EMPTY (0), ACTIVE (1..DEPTH−1), FULL (DEPTH). EMPTY→ACTIVE on push; ACTIVE→FULL on push without pop at DEPTH−1; FULL→ACTIVE on pop; ACTIVE→EMPTY on pop without push at 1; any state→EMPTY on flush or rst.

## Timing
- Reset values: count 0, pointers 0, rf_we 0, rf_waddr 0, rf_wdata 0, qry_hit 0, qry_data 0, in_ready 0 while rst is high and 1 on the first cycle after.
- Push-to-write latency: 1 cycle. An entry pushed at edge N drives rf_we at cycle N+1, and retires at the first edge where rf_gnt is 1.
- rf_gnt held high gives one retirement per cycle.
- rf_gnt low holds rf_we, rf_waddr and rf_wdata stable.
- qry outputs reflect state after the previous edge; the same-cycle datain is not visible to the bypass.
- rst mid-operation: all pending entries are lost and no rf_we is issued afterwards.

## Structure
- Shared package: DW and AW defaults, the register-zero constant, and a wb_entry struct {dest, data}.
- One sub-module is natural: wb_fifo, holding storage, pointers, count, and the flush/push/pop logic. The top holds the dest == 0 filter, the rf port mapping, and the bypass search.

## Test plan
- Reset then push 0x1234 to R3 with rf_gnt=1 → rf_we=1, rf_waddr=3, rf_wdata=0x1234 one cycle later; count returns to 0 after the next edge.
- rf_gnt=0, push 5 results → in_ready drops after 4 pushes and count=4; the fifth waits. Raise rf_gnt → four writes in order, then the fifth.
- Push R2=0x0001 then R2=0x0002 with rf_gnt=0, qry_addr=2 → qry_hit=1, qry_data=0x0002; both writes are later issued, 0x0001 first.
- Push to R0 with value 0xFFFF → count stays 0, rf_we stays 0, qry with addr 0 gives hit 0.
- With 3 entries pending, assert flush together with in_valid and rf_gnt → next cycle count=0 and rf_we=0; the same-cycle input is lost.
- At count=2, push and pop in the same cycle → count stays 2. Run a 100-cycle random push/grant stream and check wrap-around order against a reference queue.
